// File: rtl/control_pkg.sv
// Shared encodings for the BEAN-1 multi-cycle control unit: opcodes, FSM states
// and datapath select values.
package control_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    REG_ALU = 2'd0,
    REG_MEM = 2'd1,
    REG_PC4 = 2'd2,
    REG_IMM = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4     = 2'd0,
    PC_ALU       = 2'd1,
    PC_ALU_ALIGN = 2'd2,
    PC_TRAP      = 2'd3
  } pc_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic     rs1_sel;
    logic     rs2_sel;
    reg_sel_e reg_sel;
    pc_sel_e  pc_sel;
    logic     reg_we;
    logic     pc_en;
    logic     mem_op;
  } exec_ctl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: maps opcode/funct fields and the current
// state to EXEC-cycle selects, immediate format, ALU mode and the illegal flag.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  state_e     state_i,
  output exec_ctl_t  exec_ctl_o,
  output imm_sel_e   imm_sel_o,
  output logic [3:0] alu_mode_o,
  output logic       is_branch_o,
  output logic       is_store_o,
  output logic       illegal_o
);

  always_comb begin
    exec_ctl_o  = '0;
    imm_sel_o   = IMM_I;
    alu_mode_o  = 4'b0000;
    is_branch_o = 1'b0;
    is_store_o  = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OPC_LUI: begin
        imm_sel_o          = IMM_U;
        exec_ctl_o.reg_we  = 1'b1;
        exec_ctl_o.reg_sel = REG_IMM;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_o          = IMM_U;
        exec_ctl_o.rs1_sel = 1'b1;
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.reg_we  = 1'b1;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_OP: begin
        alu_mode_o        = {funct7_i[5], funct3_i};
        exec_ctl_o.reg_we = 1'b1;
        exec_ctl_o.pc_en  = 1'b1;
        illegal_o         = !((funct7_i == 7'b0000000) || (funct7_i == 7'b0100000));
      end
      OPC_OP_IMM: begin
        // funct7[5] only selects SRA vs SRL; elsewhere bit 30 is immediate data.
        alu_mode_o         = {(funct3_i == 3'b101) & funct7_i[5], funct3_i};
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.reg_we  = 1'b1;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_o          = IMM_J;
        exec_ctl_o.rs1_sel = 1'b1;
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.reg_we  = 1'b1;
        exec_ctl_o.reg_sel = REG_PC4;
        exec_ctl_o.pc_sel  = PC_ALU;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_JALR: begin
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.reg_we  = 1'b1;
        exec_ctl_o.reg_sel = REG_PC4;
        exec_ctl_o.pc_sel  = PC_ALU_ALIGN;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_BRANCH: begin
        // The ALU forms the target PC + B-imm; the comparator reads rs1/rs2
        // straight from the register file and returns jump in the same cycle.
        imm_sel_o          = IMM_B;
        is_branch_o        = 1'b1;
        exec_ctl_o.rs1_sel = 1'b1;
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.pc_sel  = PC_ALU;
        exec_ctl_o.pc_en   = 1'b1;
      end
      OPC_LOAD: begin
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.mem_op  = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_o          = IMM_S;
        is_store_o         = 1'b1;
        exec_ctl_o.rs2_sel = 1'b1;
        exec_ctl_o.mem_op  = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    // The instruction register is not meaningful before decode or after a trap.
    if ((state_i == S_RST) || (state_i == S_FETCH) || (state_i == S_TRAP)) begin
      imm_sel_o  = IMM_I;
      alu_mode_o = 4'b0000;
    end
  end

endmodule

// File: rtl/control_fsm_mc.sv
// BEAN-1 multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing with a
// memory handshake, reset hold-off, per-access timeout and illegal-op trap.
module control_fsm_mc
  import control_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int HALT_ON_TRAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        jump,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        reg_WE,
  output logic        rs1_SEL,
  output logic        rs2_SEL,
  output logic [1:0]  reg_SEL,
  output logic [1:0]  pc_SEL,
  output logic [2:0]  imm_SEL,
  output logic [3:0]  ALU_MODE,
  output logic        addrs_SEL,
  output logic        pc_EN,
  output logic        instr_EN,
  output logic        ALU_mem_EN,
  output logic        mem_in_EN,
  output logic        mem_WE,
  output logic [2:0]  mem_MODE,
  output logic        trap,
  output logic [2:0]  state
);

  localparam int CNT_MAX = (RESET_CYCLES > MEM_TIMEOUT) ? RESET_CYCLES : MEM_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'((RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trap_q;

  exec_ctl_t  exec_ctl;
  imm_sel_e   imm_sel;
  logic [3:0] alu_mode;
  logic       is_branch;
  logic       is_store;
  logic       illegal;
  logic       timeout;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  control_decode u_decode (
    .opcode_i    (inst[6:0]),
    .funct3_i    (inst[14:12]),
    .funct7_i    (inst[31:25]),
    .state_i     (state_q),
    .exec_ctl_o  (exec_ctl),
    .imm_sel_o   (imm_sel),
    .alu_mode_o  (alu_mode),
    .is_branch_o (is_branch),
    .is_store_o  (is_store),
    .illegal_o   (illegal)
  );

  // Terminal wait count: a ready in this same cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_RST: begin
          if ((RESET_CYCLES == 0) || (cnt_q == RST_LAST)) state_q <= S_FETCH;
          else cnt_q <= cnt_q + 1'b1;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: state_q <= exec_ctl.mem_op ? S_MEM : S_FETCH;
        S_MEM: begin
          if (mem_ready) begin
            state_q <= is_store ? S_FETCH : S_WB;
          end else if (timeout) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: state_q <= S_FETCH;
        S_TRAP: if (HALT_ON_TRAP == 0) state_q <= S_FETCH;
        default: state_q <= S_RST;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    reg_WE     = 1'b0;
    rs1_SEL    = 1'b0;
    rs2_SEL    = 1'b0;
    reg_SEL    = REG_ALU;
    pc_SEL     = PC_PLUS4;
    addrs_SEL  = 1'b0;
    pc_EN      = 1'b0;
    instr_EN   = 1'b0;
    ALU_mem_EN = 1'b0;
    mem_in_EN  = 1'b0;
    mem_WE     = 1'b0;
    mem_MODE   = MODE_WORD;
    imm_SEL    = imm_sel;
    ALU_MODE   = alu_mode;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        instr_EN = mem_ready;
      end
      S_EXEC: begin
        rs1_SEL    = exec_ctl.rs1_sel;
        rs2_SEL    = exec_ctl.rs2_sel;
        reg_SEL    = exec_ctl.reg_sel;
        pc_SEL     = is_branch ? (jump ? PC_ALU : PC_PLUS4) : exec_ctl.pc_sel;
        reg_WE     = exec_ctl.reg_we;
        pc_EN      = exec_ctl.pc_en;
        ALU_mem_EN = exec_ctl.mem_op;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        addrs_SEL = 1'b1;
        mem_MODE  = inst[14:12];
        mem_WE    = is_store;
        mem_in_EN = mem_ready & ~is_store;
        pc_EN     = mem_ready & is_store;
      end
      S_WB: begin
        reg_WE  = 1'b1;
        reg_SEL = REG_MEM;
        pc_EN   = 1'b1;
      end
      S_TRAP: begin
        if (HALT_ON_TRAP == 0) begin
          pc_SEL = PC_TRAP;
          pc_EN  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign trap  = trap_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_fsm_mc.sv
// Directed bench for control_fsm_mc: a halting instance (a_*) and a resuming
// instance (b_*) share stimulus; single-instruction vectors plus hand sequences.
module tb_control_fsm_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        jump = 1'b0;
  logic        mem_ready = 1'b0;

  logic       a_mem_req, a_reg_WE, a_rs1_SEL, a_rs2_SEL, a_addrs_SEL, a_pc_EN;
  logic       a_instr_EN, a_ALU_mem_EN, a_mem_in_EN, a_mem_WE, a_trap;
  logic [1:0] a_reg_SEL, a_pc_SEL;
  logic [2:0] a_imm_SEL, a_mem_MODE, a_state;
  logic [3:0] a_ALU_MODE;

  logic       b_mem_req, b_reg_WE, b_rs1_SEL, b_rs2_SEL, b_addrs_SEL, b_pc_EN;
  logic       b_instr_EN, b_ALU_mem_EN, b_mem_in_EN, b_mem_WE, b_trap;
  logic [1:0] b_reg_SEL, b_pc_SEL;
  logic [2:0] b_imm_SEL, b_mem_MODE, b_state;
  logic [3:0] b_ALU_MODE;

  control_fsm_mc #(.RESET_CYCLES(2), .MEM_TIMEOUT(16), .HALT_ON_TRAP(1)) dut_a (
    .clk(clk), .reset(reset), .inst(inst), .jump(jump), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .reg_WE(a_reg_WE), .rs1_SEL(a_rs1_SEL), .rs2_SEL(a_rs2_SEL),
    .reg_SEL(a_reg_SEL), .pc_SEL(a_pc_SEL), .imm_SEL(a_imm_SEL), .ALU_MODE(a_ALU_MODE),
    .addrs_SEL(a_addrs_SEL), .pc_EN(a_pc_EN), .instr_EN(a_instr_EN),
    .ALU_mem_EN(a_ALU_mem_EN), .mem_in_EN(a_mem_in_EN), .mem_WE(a_mem_WE),
    .mem_MODE(a_mem_MODE), .trap(a_trap), .state(a_state)
  );

  control_fsm_mc #(.RESET_CYCLES(2), .MEM_TIMEOUT(16), .HALT_ON_TRAP(0)) dut_b (
    .clk(clk), .reset(reset), .inst(inst), .jump(jump), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .reg_WE(b_reg_WE), .rs1_SEL(b_rs1_SEL), .rs2_SEL(b_rs2_SEL),
    .reg_SEL(b_reg_SEL), .pc_SEL(b_pc_SEL), .imm_SEL(b_imm_SEL), .ALU_MODE(b_ALU_MODE),
    .addrs_SEL(b_addrs_SEL), .pc_EN(b_pc_EN), .instr_EN(b_instr_EN),
    .ALU_mem_EN(b_ALU_mem_EN), .mem_in_EN(b_mem_in_EN), .mem_WE(b_mem_WE),
    .mem_MODE(b_mem_MODE), .trap(b_trap), .state(b_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        jump;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic        rs1;
    logic        rs2;
    logic [1:0]  reg_sel;
    logic [1:0]  pc_sel;
    logic        reg_we;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"lui",    32'h00000037, 1'b0, 3'd3, 4'h0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1};
    vecs[1] = '{"auipc",  32'h00000097, 1'b0, 3'd3, 4'h0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
    vecs[2] = '{"sub",    32'h402081B3, 1'b0, 3'd0, 4'h8, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[3] = '{"slt",    32'h0020A1B3, 1'b0, 3'd0, 4'h2, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[4] = '{"srai",   32'h4030D093, 1'b0, 3'd0, 4'hD, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
    vecs[5] = '{"addi",   32'h40008093, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
    vecs[6] = '{"jal",    32'h000000EF, 1'b0, 3'd4, 4'h0, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1};
    vecs[7] = '{"jalr",   32'h000100E7, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1};
    vecs[8] = '{"beq_t",  32'h00208463, 1'b1, 3'd2, 4'h0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    vecs[9] = '{"beq_nt", 32'h00208463, 1'b0, 3'd2, 4'h0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};

    // Reset held for three cycles: everything quiet, word mode.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst.state", a_state, 0);
      chk("rst.outs", {a_mem_req, a_reg_WE, a_pc_EN, a_instr_EN, a_ALU_mem_EN, a_mem_in_EN,
                       a_mem_WE, a_trap, a_rs1_SEL, a_rs2_SEL, a_addrs_SEL, a_reg_SEL,
                       a_pc_SEL, a_imm_SEL, a_ALU_MODE}, 0);
      chk("rst.mode", a_mem_MODE, 3'b010);
    end
    reset = 1'b0;
    #1;
    chk("holdoff.c1", a_state, 0);
    cyc();
    chk("holdoff.c2", a_state, 0);
    chk("holdoff.req", a_mem_req, 0);
    cyc();
    chk("fetch.state", a_state, 1);
    chk("fetch.req", a_mem_req, 1);
    chk("fetch.addr", a_addrs_SEL, 0);
    chk("fetch.ien_idle", a_instr_EN, 0);

    // Single-cycle-execute instructions, memory ready immediately.
    for (int i = 0; i < 10; i++) begin
      inst = vecs[i].inst;
      jump = vecs[i].jump;
      mem_ready = 1'b1;
      #1;
      chk({vecs[i].name, ".instr_EN"}, a_instr_EN, 1);
      cyc();
      mem_ready = 1'b0;
      #1;
      chk({vecs[i].name, ".decode"}, a_state, 2);
      chk({vecs[i].name, ".imm"}, a_imm_SEL, vecs[i].imm);
      chk({vecs[i].name, ".alu"}, a_ALU_MODE, vecs[i].alu);
      cyc();
      chk({vecs[i].name, ".exec"}, a_state, 3);
      chk({vecs[i].name, ".rs1"}, a_rs1_SEL, vecs[i].rs1);
      chk({vecs[i].name, ".rs2"}, a_rs2_SEL, vecs[i].rs2);
      chk({vecs[i].name, ".reg_sel"}, a_reg_SEL, vecs[i].reg_sel);
      chk({vecs[i].name, ".pc_sel"}, a_pc_SEL, vecs[i].pc_sel);
      chk({vecs[i].name, ".reg_we"}, a_reg_WE, vecs[i].reg_we);
      chk({vecs[i].name, ".pc_en"}, a_pc_EN, 1);
      cyc();
      chk({vecs[i].name, ".refetch"}, a_state, 1);
      chk({vecs[i].name, ".pc_en_off"}, a_pc_EN, 0);
    end
    jump = 1'b0;

    // LW with four wait states in MEM.
    inst = 32'h0000A103;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("lw.exec", a_state, 3);
    chk("lw.alu_mem_en", a_ALU_mem_EN, 1);
    chk("lw.rs2", a_rs2_SEL, 1);
    chk("lw.exec_pc_en", a_pc_EN, 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_ready = 1'b1;
      #1;
      chk("lw.mem_state", a_state, 4);
      chk("lw.mem_req", a_mem_req, 1);
      chk("lw.addrs", a_addrs_SEL, 1);
      chk("lw.mode", a_mem_MODE, 3'b010);
      chk("lw.mem_in_en", a_mem_in_EN, (k == 4) ? 1 : 0);
      chk("lw.mem_we", a_mem_WE, 0);
      cyc();
    end
    mem_ready = 1'b0;
    chk("lw.wb", a_state, 5);
    chk("lw.wb_sel", a_reg_SEL, 1);
    chk("lw.wb_we", a_reg_WE, 1);
    chk("lw.wb_pc_en", a_pc_EN, 1);
    chk("lw.wb_req", a_mem_req, 0);
    cyc();
    chk("lw.refetch", a_state, 1);

    // SB: byte mode, write strobe, PC advances on the ready cycle.
    inst = 32'h00208023;
    mem_ready = 1'b1;
    cyc();
    chk("sb.imm", a_imm_SEL, 1);
    cyc();
    chk("sb.exec_we", a_reg_WE, 0);
    cyc();
    chk("sb.mem", a_state, 4);
    chk("sb.mem_we", a_mem_WE, 1);
    chk("sb.mode", a_mem_MODE, 3'b000);
    chk("sb.pc_en", a_pc_EN, 1);
    chk("sb.mem_in_en", a_mem_in_EN, 0);
    cyc();
    mem_ready = 1'b0;
    chk("sb.refetch", a_state, 1);

    // Fetch ready on the 16th wait cycle completes normally.
    inst = 32'h00000037;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) mem_ready = 1'b1;
      #1;
      if (k == 16) chk("to16.instr_EN", a_instr_EN, 1);
      cyc();
    end
    mem_ready = 1'b0;
    chk("to16.decode", a_state, 2);
    chk("to16.trap", a_trap, 0);
    cyc();
    cyc();
    chk("to16.refetch", a_state, 1);

    // Fetch never ready: trap after 16 wait cycles.
    for (int k = 1; k <= 16; k++) begin
      chk("to.wait_state", a_state, 1);
      chk("to.wait_req", a_mem_req, 1);
      cyc();
    end
    chk("to.trap_state", a_state, 6);
    chk("to.trap", a_trap, 1);
    chk("to.req_drop", a_mem_req, 0);
    chk("to.halt_pc_en", a_pc_EN, 0);
    chk("to.b_state", b_state, 6);
    chk("to.b_pc_en", b_pc_EN, 1);
    chk("to.b_pc_sel", b_pc_SEL, 3);
    cyc();
    chk("to.a_parked", a_state, 6);
    chk("to.b_refetch", b_state, 1);
    chk("to.b_sticky", b_trap, 1);
    chk("to.b_req", b_mem_req, 1);

    // Reset in the middle of a fetch aborts it on the following edge.
    reset = 1'b1;
    #1;
    chk("abort.req_before", b_mem_req, 1);
    cyc();
    chk("abort.req_after", b_mem_req, 0);
    chk("abort.b_state", b_state, 0);
    chk("abort.b_trap", b_trap, 0);
    chk("abort.a_trap", a_trap, 0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("abort.refetch", a_state, 1);

    // Illegal opcode: halting instance parks, resuming one redirects once.
    inst = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("ill.decode", a_state, 2);
    cyc();
    chk("ill.trap_state", a_state, 6);
    chk("ill.trap", a_trap, 1);
    chk("ill.a_pc_en", a_pc_EN, 0);
    chk("ill.b_pc_en", b_pc_EN, 1);
    chk("ill.b_pc_sel", b_pc_SEL, 3);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("ill.a_state", a_state, 6);
      chk("ill.a_pc_en", a_pc_EN, 0);
      chk("ill.a_reg_we", a_reg_WE, 0);
      if (k == 0) chk("ill.b_refetch", b_state, 1);
    end

    // OP with an unsupported funct7 traps as well.
    inst = 32'h02208133;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("f7.decode", b_state, 2);
    cyc();
    chk("f7.trap", b_state, 6);
    chk("f7.pc_en", b_pc_EN, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
